// File: rtl/codec_pkg.sv
// Shared types and constants for the audio codec init sequencer.
//   entry_t       : one init table entry (register address, data byte)
//   state_t       : sequencer states
//   DELAY_MARKER  : table address meaning "wait data*1024 cycles"
//   DEFAULT_TABLE : power-on register programme for the codec
package codec_pkg;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } entry_t;

   typedef enum logic [3:0] {
      PWR_WAIT, FETCH, WR, WR_WAIT, RD, RD_WAIT,
      CHECK, DELAY, IDLE, HOST, HOST_WAIT, FAIL
   } state_t;

   localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

   localparam int DEFAULT_DEPTH = 16;
   typedef entry_t [DEFAULT_DEPTH-1:0] table_t;

   function automatic table_t default_table();
      table_t t;
      t[0]  = {16'h0001, 8'h80};
      t[1]  = {16'h0002, 8'h00};
      t[2]  = {16'h0004, 8'h11};
      t[3]  = {16'h0010, 8'h3C};
      t[4]  = {16'h0011, 8'h3C};
      t[5]  = {16'h0020, 8'h05};
      t[6]  = {16'h0021, 8'h0A};
      t[7]  = {16'h0030, 8'h01};
      t[8]  = {16'h0031, 8'h20};
      t[9]  = {16'h0040, 8'h60};
      t[10] = {16'h0041, 8'h60};
      t[11] = {16'h0050, 8'h0F};
      t[12] = {16'h0051, 8'h00};
      t[13] = {16'h0060, 8'hA5};
      t[14] = {16'h0070, 8'h5A};
      t[15] = {16'h0080, 8'h01};
      return t;
   endfunction

   localparam table_t DEFAULT_TABLE = default_table();

endpackage

// File: rtl/codec_init_rom.sv
// Synchronous-read init table ROM, one cycle of read latency.
//   clk, rst_n : clock, async active-low reset
//   index      : entry index
//   entry      : table contents at index, registered
module codec_init_rom
   import codec_pkg::*;
#(
   parameter int                       NUM_ENTRIES = 16,
   parameter entry_t [NUM_ENTRIES-1:0] TABLE       = DEFAULT_TABLE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [$clog2(NUM_ENTRIES)-1:0] index,
   output entry_t                         entry
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) entry <= '0;
      else        entry <= TABLE[index];
   end

endmodule

// File: rtl/codec_init_sequencer.sv
// Audio codec init sequencer: waits out codec power-up, walks the init table
// over the I2C controller (optional read-back verify with retries), then
// arbitrates single-register host accesses onto the same controller.
//   clk, rst_n            : clock, async active-low reset
//   init_go               : pulse, rerun the table from entry 0 (no power-up wait)
//   init_busy/done/fail   : sequence status; done and fail are sticky
//   fail_index            : entry that exhausted its retries
//   host_req/rnw/address/wdata : host access, held until host_ack
//   host_ack/rdata/err    : one-cycle completion with read data and NACK flag
//   i2c_start/rnw/address/wdata : controller request, fields held until i2c_done
//   i2c_done/rdata/nack   : controller completion
//
// state     | meaning
// PWR_WAIT  | codec power-up wait after reset
// FETCH     | read table entry (2 cycles: ROM address, ROM data)
// WR        | issue table write
// WR_WAIT   | wait for write completion
// RD        | issue verify read
// RD_WAIT   | wait for read completion
// CHECK     | compare read-back against table data
// DELAY     | delay-marker entry, wait data*1024 cycles
// IDLE      | init complete, serving host accesses
// HOST      | issue host access
// HOST_WAIT | wait for host access completion
// FAIL      | an entry exhausted its retries, still serves host accesses
module codec_init_sequencer
   import codec_pkg::*;
#(
   parameter int                       NUM_ENTRIES    = 16,
   parameter int                       VERIFY         = 1,
   parameter int                       MAX_RETRIES    = 3,
   parameter int                       POWERUP_CYCLES = 1_000_000,
   parameter entry_t [NUM_ENTRIES-1:0] INIT_TABLE     = DEFAULT_TABLE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           init_go,
   output logic                           init_busy,
   output logic                           init_done,
   output logic                           init_fail,
   output logic [$clog2(NUM_ENTRIES)-1:0] fail_index,
   input  logic                           host_req,
   input  logic                           host_rnw,
   input  logic [15:0]                    host_address,
   input  logic [7:0]                     host_wdata,
   output logic                           host_ack,
   output logic [7:0]                     host_rdata,
   output logic                           host_err,
   output logic                           i2c_start,
   output logic                           i2c_rnw,
   output logic [15:0]                    i2c_address,
   output logic [7:0]                     i2c_wdata,
   input  logic [7:0]                     i2c_rdata,
   input  logic                           i2c_done,
   input  logic                           i2c_nack
);

   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int RW = $clog2(MAX_RETRIES + 2);

   state_t        state;
   logic [IW-1:0] index;
   logic [RW-1:0] retry_cnt;
   logic [31:0]   timer;
   logic          fetch_phase;
   logic          rd_nack;
   logic [7:0]    rd_data;
   entry_t        rom_entry;
   logic          step_ok;
   logic          step_bad;
   logic          last_entry;

   codec_init_rom #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .TABLE       (INIT_TABLE)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .index (index),
      .entry (rom_entry)
   );

   assign last_entry = (index == IW'(NUM_ENTRIES - 1));

   // Entry outcome: step_ok advances to the next entry, step_bad retries.
   always_comb begin
      step_ok  = 1'b0;
      step_bad = 1'b0;
      case (state)
         WR_WAIT: if (i2c_done) begin
            if (i2c_nack)         step_bad = 1'b1;
            else if (VERIFY == 0) step_ok  = 1'b1;
         end
         CHECK: begin
            if (rd_nack || (rd_data != i2c_wdata)) step_bad = 1'b1;
            else                                   step_ok  = 1'b1;
         end
         DELAY: if (timer <= 32'd1) step_ok = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= PWR_WAIT;
         timer       <= 32'(POWERUP_CYCLES);
         index       <= '0;
         retry_cnt   <= '0;
         fetch_phase <= 1'b0;
         rd_nack     <= 1'b0;
         rd_data     <= '0;
         i2c_start   <= 1'b0;
         i2c_rnw     <= 1'b0;
         i2c_address <= '0;
         i2c_wdata   <= '0;
         host_ack    <= 1'b0;
         host_rdata  <= '0;
         host_err    <= 1'b0;
         init_busy   <= 1'b1;
         init_done   <= 1'b0;
         init_fail   <= 1'b0;
         fail_index  <= '0;
      end else begin
         i2c_start <= 1'b0;
         host_ack  <= 1'b0;
         case (state)
            PWR_WAIT: begin
               if (timer <= 32'd1) begin
                  index <= '0;
                  state <= FETCH;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            FETCH: begin
               fetch_phase <= ~fetch_phase;
               if (fetch_phase) begin
                  if (rom_entry.addr == DELAY_MARKER) begin
                     timer <= {14'd0, rom_entry.data, 10'd0};
                     state <= DELAY;
                  end else begin
                     i2c_rnw     <= 1'b0;
                     i2c_address <= rom_entry.addr;
                     i2c_wdata   <= rom_entry.data;
                     state       <= WR;
                  end
               end
            end
            WR: begin
               i2c_start <= 1'b1;
               state     <= WR_WAIT;
            end
            WR_WAIT: begin
               if (i2c_done && !i2c_nack && (VERIFY != 0)) begin
                  i2c_rnw <= 1'b1;
                  state   <= RD;
               end
            end
            RD: begin
               i2c_start <= 1'b1;
               state     <= RD_WAIT;
            end
            RD_WAIT: begin
               if (i2c_done) begin
                  rd_nack <= i2c_nack;
                  rd_data <= i2c_rdata;
                  state   <= CHECK;
               end
            end
            DELAY: timer <= timer - 32'd1;
            IDLE, FAIL: begin
               if (init_go) begin
                  init_done   <= 1'b0;
                  init_fail   <= 1'b0;
                  init_busy   <= 1'b1;
                  index       <= '0;
                  retry_cnt   <= '0;
                  fetch_phase <= 1'b0;
                  state       <= FETCH;
               // host_req is still high during the ack cycle; it only counts
               // as a new request once the ack has been seen.
               end else if (host_req && !host_ack) begin
                  i2c_rnw     <= host_rnw;
                  i2c_address <= host_address;
                  i2c_wdata   <= host_wdata;
                  state       <= HOST;
               end
            end
            HOST: begin
               i2c_start <= 1'b1;
               state     <= HOST_WAIT;
            end
            HOST_WAIT: begin
               if (i2c_done) begin
                  host_ack <= 1'b1;
                  host_err <= i2c_nack;
                  if (i2c_rnw) host_rdata <= i2c_rdata;
                  state    <= IDLE;
               end
            end
            default: state <= PWR_WAIT;
         endcase

         if (step_ok) begin
            retry_cnt <= '0;
            if (last_entry) begin
               init_done <= 1'b1;
               init_busy <= 1'b0;
               state     <= IDLE;
            end else begin
               index <= index + 1'b1;
               state <= FETCH;
            end
         end else if (step_bad) begin
            i2c_rnw <= 1'b0;
            if (retry_cnt == RW'(MAX_RETRIES)) begin
               init_fail  <= 1'b1;
               init_busy  <= 1'b0;
               fail_index <= index;
               state      <= FAIL;
            end else begin
               retry_cnt <= retry_cnt + 1'b1;
               state     <= WR;
            end
         end
      end
   end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: I2C controller/codec model with fault
// injection, a scoreboard of expected I2C transactions and host responses,
// and a second instance with a delay-marker table.
module tb_codec_init_sequencer;
   import codec_pkg::*;

   localparam logic [15:0] EXP_ADDR [16] = '{16'h0001, 16'h0002, 16'h0004, 16'h0010,
                                             16'h0011, 16'h0020, 16'h0021, 16'h0030,
                                             16'h0031, 16'h0040, 16'h0041, 16'h0050,
                                             16'h0051, 16'h0060, 16'h0070, 16'h0080};
   localparam logic [7:0]  EXP_DATA [16] = '{8'h80, 8'h00, 8'h11, 8'h3C, 8'h3C, 8'h05,
                                             8'h0A, 8'h01, 8'h20, 8'h60, 8'h60, 8'h0F,
                                             8'h00, 8'hA5, 8'h5A, 8'h01};
   localparam logic [15:0] NO_ADDR = 16'hEEEE;

   function automatic table_t mk_delay_table();
      table_t t;
      for (int i = 0; i < 16; i++) t[i] = {EXP_ADDR[i], EXP_DATA[i]};
      t[2] = {16'hFFFF, 8'h02};
      return t;
   endfunction
   localparam table_t DELAY_TABLE = mk_delay_table();

   typedef struct packed {logic rnw; logic [15:0] addr; logic [7:0] data;} txn_t;
   typedef struct packed {logic rnw; logic [7:0] rdata; logic err; logic done;} hexp_t;

   logic clk, rst_n;
   logic init_go, init_busy, init_done, init_fail;
   logic [3:0] fail_index;
   logic host_req, host_rnw, host_ack, host_err;
   logic [15:0] host_address;
   logic [7:0] host_wdata, host_rdata;
   logic i2c_start, i2c_rnw, i2c_done, i2c_nack;
   logic [15:0] i2c_address;
   logic [7:0] i2c_wdata, i2c_rdata;

   logic b_init_go, b_init_busy, b_init_done, b_init_fail;
   logic [3:0] b_fail_index;
   logic b_host_req, b_host_ack, b_host_err;
   logic [7:0] b_host_rdata;
   logic b_i2c_start, b_i2c_rnw, b_i2c_done, b_i2c_nack;
   logic [15:0] b_i2c_address;
   logic [7:0] b_i2c_wdata, b_i2c_rdata;

   int checks = 0, errors = 0, cyc = 0;
   int first_start_cyc = -1, rel_cyc = 0, wr3_cnt = 0, ack_cnt = 0;
   logic [15:0] nack_addr = NO_ADDR, bad_addr = NO_ADDR;
   int nack_left = 0;
   txn_t exp_q[$];
   hexp_t hq[$];
   int b_cyc[$];
   logic [15:0] b_addr[$];
   logic [7:0] mem [0:65535];
   logic [7:0] mem_b [0:65535];

   codec_init_sequencer #(.NUM_ENTRIES(16), .VERIFY(1), .MAX_RETRIES(3), .POWERUP_CYCLES(100)) dut (
      .clk(clk), .rst_n(rst_n), .init_go(init_go), .init_busy(init_busy),
      .init_done(init_done), .init_fail(init_fail), .fail_index(fail_index),
      .host_req(host_req), .host_rnw(host_rnw), .host_address(host_address),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .host_err(host_err), .i2c_start(i2c_start), .i2c_rnw(i2c_rnw),
      .i2c_address(i2c_address), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
      .i2c_done(i2c_done), .i2c_nack(i2c_nack));

   codec_init_sequencer #(.NUM_ENTRIES(16), .VERIFY(1), .MAX_RETRIES(3), .POWERUP_CYCLES(100),
                          .INIT_TABLE(DELAY_TABLE)) dut_d (
      .clk(clk), .rst_n(rst_n), .init_go(b_init_go), .init_busy(b_init_busy),
      .init_done(b_init_done), .init_fail(b_init_fail), .fail_index(b_fail_index),
      .host_req(b_host_req), .host_rnw(1'b0), .host_address(16'h0000),
      .host_wdata(8'h00), .host_ack(b_host_ack), .host_rdata(b_host_rdata),
      .host_err(b_host_err), .i2c_start(b_i2c_start), .i2c_rnw(b_i2c_rnw),
      .i2c_address(b_i2c_address), .i2c_wdata(b_i2c_wdata), .i2c_rdata(b_i2c_rdata),
      .i2c_done(b_i2c_done), .i2c_nack(b_i2c_nack));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic push_pair(input int i);
      exp_q.push_back({1'b0, EXP_ADDR[i], EXP_DATA[i]});
      exp_q.push_back({1'b1, EXP_ADDR[i], EXP_DATA[i]});
   endtask

   task automatic pulse_go();
      @(negedge clk) init_go = 1'b1;
      @(negedge clk) init_go = 1'b0;
      chk("go_busy_done", {init_busy, init_done}, 2'b10);
   endtask

   task automatic wait_done(input string name, input int budget);
      for (int n = 0; n < budget && !init_done && !init_fail; n++) @(negedge clk);
      chk(name, {init_done, init_busy, init_fail}, 3'b100);
   endtask

   task automatic host_access(input logic rnw, input logic [15:0] addr,
                              input logic [7:0] wdata, input logic go);
      host_rnw = rnw; host_address = addr; host_wdata = wdata;
      host_req = 1'b1;
      if (go) begin
         init_go = 1'b1;
         @(negedge clk);
         init_go = 1'b0;
      end
      for (int n = 0; n < 3000 && !host_ack; n++) @(negedge clk);
      chk("host_ack_seen", host_ack, 1'b1);
      host_req = 1'b0;
      @(negedge clk);
   endtask

   // Controller/codec model for the main instance.
   initial begin : model_a
      logic busy;
      int cnt;
      txn_t cap;
      busy = 0; cnt = 0; cap = '0;
      i2c_done = 0; i2c_nack = 0; i2c_rdata = 0;
      forever begin
         @(negedge clk);
         i2c_done = 0; i2c_nack = 0;
         if (!rst_n) busy = 0;
         else if (i2c_start) begin
            busy = 1; cnt = 3; cap = {i2c_rnw, i2c_address, i2c_wdata};
         end else if (busy) begin
            if (cnt == 0) begin
               busy = 0;
               i2c_done = 1;
               chk("i2c_fields_held", {i2c_rnw, i2c_address, i2c_wdata}, cap);
               if (!cap.rnw) begin
                  if (cap.addr == nack_addr && nack_left > 0) begin
                     i2c_nack = 1; nack_left--;
                  end else mem[cap.addr] = cap.data;
               end else begin
                  i2c_rdata = mem[cap.addr] ^ ((cap.addr == bad_addr) ? 8'hFF : 8'h00);
               end
            end else cnt--;
         end
      end
   end

   initial begin : model_b
      logic busy;
      int cnt;
      txn_t cap;
      busy = 0; cnt = 0; cap = '0;
      b_i2c_done = 0; b_i2c_nack = 0; b_i2c_rdata = 0;
      forever begin
         @(negedge clk);
         b_i2c_done = 0;
         if (!rst_n) busy = 0;
         else if (b_i2c_start) begin
            busy = 1; cnt = 3; cap = {b_i2c_rnw, b_i2c_address, b_i2c_wdata};
         end else if (busy) begin
            if (cnt == 0) begin
               busy = 0;
               b_i2c_done = 1;
               if (!cap.rnw) mem_b[cap.addr] = cap.data;
               else b_i2c_rdata = mem_b[cap.addr];
            end else cnt--;
         end
      end
   end

   // I2C scoreboard monitor.
   initial begin : mon_i2c
      txn_t e;
      forever begin
         @(negedge clk);
         if (rst_n && i2c_start) begin
            if (first_start_cyc < 0) first_start_cyc = cyc;
            if (!i2c_rnw && i2c_address == EXP_ADDR[3]) wr3_cnt++;
            if (exp_q.size() == 0) chk("i2c_unexpected_start", i2c_start, 1'b0);
            else begin
               e = exp_q.pop_front();
               chk("i2c_rnw", i2c_rnw, e.rnw);
               chk("i2c_address", i2c_address, e.addr);
               if (!e.rnw) chk("i2c_wdata", i2c_wdata, e.data);
            end
         end
      end
   end

   initial begin : mon_host
      hexp_t h;
      forever begin
         @(negedge clk);
         if (rst_n && host_ack) begin
            ack_cnt++;
            if (hq.size() == 0) chk("host_unexpected_ack", host_ack, 1'b0);
            else begin
               h = hq.pop_front();
               chk("host_err", host_err, h.err);
               if (h.rnw) chk("host_rdata", host_rdata, h.rdata);
               chk("host_ack_init_done", init_done, h.done);
            end
         end
      end
   end

   initial begin : mon_b
      forever begin
         @(negedge clk);
         if (rst_n && b_i2c_start) begin
            b_cyc.push_back(cyc);
            b_addr.push_back(b_i2c_address);
            chk("b_no_marker_access", b_i2c_address, (b_i2c_address == 16'hFFFF) ? 16'h0000 : b_i2c_address);
         end
      end
   end

   initial begin : stim
      rst_n = 0; init_go = 0; host_req = 0; host_rnw = 0; host_address = 0; host_wdata = 0;
      b_init_go = 0; b_host_req = 0;
      repeat (3) @(negedge clk);
      chk("rst_i2c", {i2c_start, i2c_rnw, i2c_address, i2c_wdata}, 0);
      chk("rst_host", {host_ack, host_err, host_rdata}, 0);
      chk("rst_status", {init_busy, init_done, init_fail, fail_index}, 7'b1000000);

      // Full init with a host write queued behind it, then a host read back.
      for (int i = 0; i < 16; i++) push_pair(i);
      exp_q.push_back({1'b0, 16'h0040, 8'h7F});
      hq.push_back({1'b0, 8'h00, 1'b0, 1'b1});
      first_start_cyc = -1;
      rel_cyc = cyc;
      rst_n = 1;
      repeat (20) @(negedge clk);
      chk("init_busy_during", init_busy, 1'b1);
      host_access(1'b0, 16'h0040, 8'h7F, 1'b0);
      chk_range("powerup_wait", first_start_cyc - rel_cyc, 101, 105);
      chk("t1_status", {init_done, init_busy, init_fail}, 3'b100);
      chk("t1_queue_empty", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      chk("t1_ack_count", ack_cnt, 1);
      exp_q.push_back({1'b1, 16'h0040, 8'h00});
      hq.push_back({1'b1, 8'h7F, 1'b0, 1'b1});
      host_access(1'b1, 16'h0040, 8'h00, 1'b0);
      chk("t1_read_queue_empty", exp_q.size(), 0);

      // Delay-marker instance.
      for (int n = 0; n < 5000 && !b_init_done; n++) @(negedge clk);
      chk("b_done", b_init_done, 1'b1);
      chk("b_start_count", b_cyc.size(), 30);
      if (b_cyc.size() >= 5) begin
         chk("b_entry1_addr", b_addr[3], EXP_ADDR[1]);
         chk("b_entry3_addr", b_addr[4], EXP_ADDR[3]);
         chk_range("b_delay_gap", b_cyc[4] - b_cyc[3], 2048, 2080);
      end

      // Entry 3 NACKed twice, then accepted.
      nack_addr = EXP_ADDR[3]; nack_left = 2; wr3_cnt = 0;
      for (int i = 0; i < 3; i++) push_pair(i);
      exp_q.push_back({1'b0, EXP_ADDR[3], EXP_DATA[3]});
      exp_q.push_back({1'b0, EXP_ADDR[3], EXP_DATA[3]});
      for (int i = 3; i < 16; i++) push_pair(i);
      pulse_go();
      wait_done("t2_status", 2000);
      chk("t2_entry3_writes", wr3_cnt, 3);
      chk("t2_queue_empty", exp_q.size(), 0);
      nack_addr = NO_ADDR;

      // Entry 5 always reads back wrong: four attempts then FAIL.
      bad_addr = EXP_ADDR[5];
      for (int i = 0; i < 5; i++) push_pair(i);
      for (int r = 0; r < 4; r++) push_pair(5);
      pulse_go();
      for (int n = 0; n < 2000 && !init_fail; n++) @(negedge clk);
      chk("t3_status", {init_fail, init_done, init_busy}, 3'b100);
      chk("t3_fail_index", fail_index, 4'd5);
      repeat (40) @(negedge clk);
      chk("t3_queue_empty", exp_q.size(), 0);
      bad_addr = NO_ADDR;
      exp_q.push_back({1'b1, 16'h0001, 8'h00});
      hq.push_back({1'b1, 8'h80, 1'b0, 1'b0});
      host_access(1'b1, 16'h0001, 8'h00, 1'b0);
      chk("t3_fail_sticky", {init_fail, fail_index}, 5'b10101);

      // init_go and host_req together: the sequence wins, host follows.
      for (int i = 0; i < 16; i++) push_pair(i);
      exp_q.push_back({1'b0, 16'h0041, 8'h33});
      hq.push_back({1'b0, 8'h00, 1'b0, 1'b1});
      host_access(1'b0, 16'h0041, 8'h33, 1'b1);
      chk("t4_status", {init_done, init_busy, init_fail}, 3'b100);
      chk("t4_queue_empty", exp_q.size(), 0);

      // Reset in the middle of the first write.
      exp_q.push_back({1'b0, EXP_ADDR[0], EXP_DATA[0]});
      pulse_go();
      for (int n = 0; n < 50 && !i2c_start; n++) @(negedge clk);
      chk("t5_start_seen", i2c_start, 1'b1);
      #2 rst_n = 0;
      #1 chk("t5_rst_outputs", {i2c_start, i2c_address, init_busy, init_done},
             {1'b0, 16'h0000, 1'b1, 1'b0});
      repeat (3) @(negedge clk);
      chk("t5_queue_empty_at_reset", exp_q.size(), 0);
      for (int i = 0; i < 16; i++) push_pair(i);
      first_start_cyc = -1;
      rel_cyc = cyc;
      rst_n = 1;
      wait_done("t5_status", 2000);
      chk_range("t5_powerup_rerun", first_start_cyc - rel_cyc, 101, 105);
      chk("t5_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/codec_init_sequencer.md
# codec_init_sequencer

Sequences the audio codec's register configuration over the I2C controller. After reset it waits out the codec power-up time, then walks an initialisation table of (register address, data) writes. Each write is optionally read back and verified, with bounded retries. Once initialisation finishes, it arbitrates single-register host accesses onto the same I2C controller; these are used for runtime volume and mute changes. It sits between the deck control logic and `i2c_controller`, and is the only master of that controller.

## Interface
Parameters:
- NUM_ENTRIES, 16: initialisation table depth.
- VERIFY, 1: 1 = read back and compare every table write.
- MAX_RETRIES, 3: re-attempts per entry after the first failure.
- POWERUP_CYCLES, 1_000_000: cycles to wait after reset before the first transaction (10 ms at 100 MHz).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: system clock.
  - rst_n, in, 1: asynchronous active-low reset.
- Initialisation control and status:
  - init_go, in, 1: pulse; reruns the table from entry 0 with no power-up wait.
  - init_busy, out, 1: sequence in progress.
  - init_done, out, 1: all entries succeeded; sticky until the next init_go or reset.
  - init_fail, out, 1: an entry exhausted its retries; sticky.
  - fail_index, out, $clog2(NUM_ENTRIES): index of the failing entry.
- Host access port:
  - host_req, in, 1: held high until host_ack.
  - host_rnw, host_address[15:0], host_wdata[7:0], in: held stable while host_req is high.
  - host_ack, out, 1: one-cycle completion pulse.
  - host_rdata, out, 8: read data, valid with host_ack.
  - host_err, out, 1: NACK flag, valid with host_ack.
- I2C controller side:
  - i2c_start, out, 1: one-cycle pulse.
  - i2c_rnw, i2c_address[15:0], i2c_wdata[7:0], out: registered; held stable from i2c_start until i2c_done.
  - i2c_rdata, in, 8: read data, valid with i2c_done.
  - i2c_done, in, 1: one-cycle end-of-transaction pulse.
  - i2c_nack, in, 1: NACK flag, valid with i2c_done.

## Operation
- States: PWR_WAIT, FETCH, WR, WR_WAIT, RD, RD_WAIT, CHECK, DELAY, IDLE, HOST, HOST_WAIT, FAIL.
- PWR_WAIT: count POWERUP_CYCLES, then go to FETCH with index 0.
- FETCH: read the table entry at index.
  - Address 16'hFFFF is a delay marker: go to DELAY and wait wdata×1024 cycles, then advance index.
  - Any other address: go to WR.
- WR: pulse i2c_start with rnw=0, then go to WR_WAIT.
- WR_WAIT, on i2c_done:
  - NACK: failure.
  - VERIFY=1: go to RD.
  - Otherwise: advance index.
- RD: pulse i2c_start with rnw=1, same address; then go to RD_WAIT.
- RD_WAIT: on i2c_done, go to CHECK.
- CHECK:
  - NACK or rdata≠wdata: failure.
  - Otherwise: advance index.
- Failure: increment the retry counter and return to WR. If the counter would exceed MAX_RETRIES, go to FAIL: set init_fail, latch fail_index, clear init_busy.
- Advance: clear the retry counter and increment index. Index == NUM_ENTRIES-1 completing → go to IDLE and set init_done. Index never wraps.
- IDLE: init_go has priority over host_req in the same cycle.
  - init_go: clear done/fail and go to FETCH at index 0.
  - host_req: copy the host fields to the i2c registers, then go to HOST.
- HOST: pulse i2c_start, then go to HOST_WAIT.
- HOST_WAIT, on i2c_done: pulse host_ack, drive host_rdata (reads only) and host_err, then return to IDLE.
- FAIL: accepts both init_go and host_req, with the same priority as IDLE.
- Busy states: init_go and host_req are ignored. host_req stays pending and is served after the sequence.
- No timeout on i2c_done. The controller guarantees completion.

## Timing
- Reset values: i2c_start=0, i2c_rnw=0, i2c_address=0, i2c_wdata=0, host_ack=0, host_rdata=0, host_err=0, init_busy=1, init_done=0, init_fail=0, fail_index=0. State after reset is PWR_WAIT.
- Reset asserted mid-transaction: outputs return to reset values immediately; the sequence restarts with the full power-up wait.
- i2c_start asserts exactly one cycle after entering WR, RD or HOST.
- The i2c fields are registered one cycle before or with i2c_start and never change before i2c_done.
- host_ack pulses the cycle after i2c_done. host_req may drop the cycle after host_ack; a still-high host_req is a new request.
- i2c_done arriving in a non-WAIT state is ignored.
- Table read latency is 1 cycle (synchronous ROM); FETCH occupies 2 cycles.

## Structure
- Package codec_pkg holds:
  - the entry struct {logic [15:0] addr; logic [7:0] data;};
  - the state enum;
  - the constant DELAY_MARKER = 16'hFFFF;
  - the default table contents.
- Sub-module codec_init_rom: synchronous read, indexed by $clog2(NUM_ENTRIES), initialised from the codec_pkg table.

## Test plan
- Reset, codec model ACKs everything, VERIFY=1, POWERUP_CYCLES=100: 16 write/read pairs in table order, first i2c_start at cycle 101 or later, init_done=1, init_busy=0.
- Model NACKs entry 3 twice, then ACKs: exactly 3 writes to entry 3's address, init_done=1, init_fail=0.
- Model returns wrong read data for entry 5 forever: 4 write+read attempts, init_fail=1, fail_index=5, and no transaction to entry 6.
- Table entry 2 = {FFFF, 8'h02}: 2048-cycle gap with no i2c_start between entry 1 and entry 3, and no I2C access to FFFF.
- host_req asserted during init (write 0x0040 ← 0x7F): served only after init_done; one i2c_start; host_ack pulses once; host_err=0. A host read returns the model's value on host_rdata.
- init_go and host_req in the same IDLE cycle: the sequence restarts at entry 0 and host_ack follows the sequence. rst_n low mid-write: i2c_start=0 immediately and the power-up wait reruns.
